// File: rtl/servo_seq_pkg.sv
// Shared types and default timing constants for the servo frame sequencer.
// width_cycles() turns a position word into a pulse length in clk cycles.
package servo_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      PULSE = 2'd2,
      WAIT  = 2'd3
   } state_e;

   localparam int unsigned DEF_NCH      = 4;
   localparam int unsigned DEF_POS_W    = 8;
   localparam int unsigned DEF_US_DIV   = 12;
   localparam int unsigned DEF_FRAME_US = 20000;
   localparam int unsigned DEF_MIN_US   = 1000;
   localparam int unsigned DEF_STEP_US  = 4;

   function automatic int unsigned width_cycles(
      input int unsigned pos,
      input int unsigned min_us,
      input int unsigned step_us,
      input int unsigned us_div
   );
      return (min_us + pos * step_us) * us_div;
   endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame-position counter for the servo sequencer: counts from the LOAD cycle,
// flags the last cycle of the frame and emits the registered frame_start pulse.
module servo_frame_timer #(
   parameter int unsigned FRAME_CYC = 240000,
   parameter int unsigned CNT_W     = 18
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic load,
   output logic frame_end,
   output logic frame_start
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYC - 1);

   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             frame_start_q, frame_start_d;

   assign frame_end   = run && (frame_cnt_q == LAST_CNT);
   assign frame_start = frame_start_q;

   // Wrapping at the frame end puts the counter at 0 in the following LOAD cycle.
   always_comb begin
      frame_cnt_d   = '0;
      frame_start_d = load;
      if (run && !frame_end) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         frame_cnt_q   <= frame_cnt_d;
         frame_start_q <= frame_start_d;
      end
   end

endmodule

// File: rtl/servo_sequencer.sv
// servo_sequencer: one shared down-counter times back-to-back pulses on NCH servo outputs per frame.
// Define SERVO_SEQ_LED_EN to build the led0 frame heartbeat; otherwise led0 is tied low.
//
// state | meaning
// IDLE  | stopped, all outputs low, waiting for en
// LOAD  | one cycle: snapshot positions into shadows, arm channel 0
// PULSE | servo[ch] high until its pulse counter expires, then next channel
// WAIT  | all outputs low until the frame period elapses
module servo_sequencer
   import servo_seq_pkg::*;
#(
   parameter int unsigned NCH      = DEF_NCH,
   parameter int unsigned POS_W    = DEF_POS_W,
   parameter int unsigned US_DIV   = DEF_US_DIV,
   parameter int unsigned FRAME_US = DEF_FRAME_US,
   parameter int unsigned MIN_US   = DEF_MIN_US,
   parameter int unsigned STEP_US  = DEF_STEP_US
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wr_en,
   input  logic [2:0]       wr_ch,
   input  logic [POS_W-1:0] wr_pos,
   output logic [NCH-1:0]   servo,
   output logic             frame_start,
   output logic             busy,
   output logic             led0
);

   localparam int unsigned FRAME_CYC = FRAME_US * US_DIV;
   localparam int unsigned CNT_W     = $clog2(FRAME_CYC);
   localparam int unsigned W_MAX     =
      width_cycles((32'd1 << POS_W) - 32'd1, MIN_US, STEP_US, US_DIV);
   localparam logic [POS_W-1:0] POS_CENTER = {1'b1, {(POS_W-1){1'b0}}};

   if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("servo_sequencer: NCH must be in 1..8");
   end
   if (NCH * W_MAX >= FRAME_CYC) begin : g_bad_frame
      $error("servo_sequencer: NCH widest pulses do not fit in one frame");
   end

   state_e                     state_q, state_d;
   logic [2:0]                 ch_q, ch_d;
   logic [CNT_W-1:0]           pulse_cnt_q, pulse_cnt_d;
   logic [NCH-1:0]             servo_q, servo_d;
   logic [POS_W-1:0]           pos_q    [NCH];
   logic [POS_W-1:0]           pos_d    [NCH];
   logic [POS_W-1:0]           shadow_q [NCH];
   logic [POS_W-1:0]           shadow_d [NCH];
   logic [POS_W-1:0]           next_pos;
   logic                       last_ch;
   logic                       frame_end;
   logic                       in_load;

   function automatic logic [CNT_W-1:0] width_m1(input logic [POS_W-1:0] p);
      return CNT_W'(width_cycles(32'(p), MIN_US, STEP_US, US_DIV) - 32'd1);
   endfunction

   assign busy    = (state_q != IDLE);
   assign in_load = (state_q == LOAD);
   assign servo   = servo_q;

   servo_frame_timer #(
      .FRAME_CYC (FRAME_CYC),
      .CNT_W     (CNT_W)
   ) u_frame_timer (
      .clk         (clk),
      .rst         (rst),
      .run         (busy),
      .load        (in_load),
      .frame_end   (frame_end),
      .frame_start (frame_start)
   );

   // Host writes land in pos regardless of state; out-of-range channels match no slot.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         pos_d[i] = pos_q[i];
         if (wr_en && (wr_ch == 3'(i))) begin
            pos_d[i] = wr_pos;
         end
      end
   end

   always_comb begin
      next_pos = shadow_q[0];
      for (int i = 0; i < NCH; i++) begin
         if ((ch_q + 3'd1) == 3'(i)) begin
            next_pos = shadow_q[i];
         end
      end
      last_ch = (ch_q == 3'(NCH - 1));
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      pulse_cnt_d = pulse_cnt_q;
      shadow_d    = shadow_q;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            shadow_d    = pos_q;
            ch_d        = 3'd0;
            pulse_cnt_d = width_m1(pos_q[0]);
            state_d     = PULSE;
         end
         PULSE: begin
            if (pulse_cnt_q != '0) begin
               pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
            end else if (!last_ch) begin
               ch_d        = ch_q + 3'd1;
               pulse_cnt_d = width_m1(next_pos);
            end else if (frame_end) begin
               // Widest legal pulses can end exactly on the last frame cycle.
               state_d = en ? LOAD : IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (frame_end) begin
               state_d = en ? LOAD : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so servo tracks the PULSE state exactly.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         servo_d[i] = (state_d == PULSE) && (ch_d == 3'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ch_q        <= 3'd0;
         pulse_cnt_q <= '0;
         servo_q     <= '0;
         for (int i = 0; i < NCH; i++) begin
            pos_q[i]    <= POS_CENTER;
            shadow_q[i] <= POS_CENTER;
         end
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         pulse_cnt_q <= pulse_cnt_d;
         servo_q     <= servo_d;
         pos_q       <= pos_d;
         shadow_q    <= shadow_d;
      end
   end

`ifdef SERVO_SEQ_LED_EN
   logic led0_q, led0_d;

   always_comb begin
      led0_d = led0_q ^ in_load;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led0_q <= 1'b0;
      end else begin
         led0_q <= led0_d;
      end
   end

   assign led0 = led0_q;
`else
   assign led0 = 1'b0;
`endif

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench for servo_sequencer with shortened timing (1 cycle per us, 1200-cycle frame).
// A timeline model predicts every output cycle from the frame position and a position snapshot.
module tb_servo_sequencer;

   localparam int NCH       = 4;
   localparam int POS_W     = 8;
   localparam int US_DIV    = 1;
   localparam int FRAME_US  = 1200;
   localparam int MIN_US    = 10;
   localparam int STEP_US   = 1;
   localparam int FRAME_CYC = FRAME_US * US_DIV;
   localparam int BUD       = 3 * FRAME_CYC;
   localparam logic [POS_W-1:0] CENTER = 8'd128;

   logic             clk;
   logic             rst;
   logic             en;
   logic             wr_en;
   logic [2:0]       wr_ch;
   logic [POS_W-1:0] wr_pos;
   logic [NCH-1:0]   servo;
   logic             frame_start;
   logic             busy;
   logic             led0;

   int n_checks = 0;
   int n_errors = 0;

   servo_sequencer #(
      .NCH      (NCH),
      .POS_W    (POS_W),
      .US_DIV   (US_DIV),
      .FRAME_US (FRAME_US),
      .MIN_US   (MIN_US),
      .STEP_US  (STEP_US)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_pos      (wr_pos),
      .servo       (servo),
      .frame_start (frame_start),
      .busy        (busy),
      .led0        (led0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wid(input logic [POS_W-1:0] p);
      return (MIN_US + int'(p) * STEP_US) * US_DIV;
   endfunction

   // Reference model: frame position m_t (0 = LOAD cycle) and a snapshot of positions.
   bit               m_busy = 1'b0;
   int               m_t    = 0;
   bit               m_led  = 1'b0;
   logic [POS_W-1:0] m_pos  [NCH];
   logic [POS_W-1:0] m_snap [NCH];

   initial begin
      for (int i = 0; i < NCH; i++) begin
         m_pos[i]  = CENTER;
         m_snap[i] = CENTER;
      end
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_led  = 1'b0;
            for (int i = 0; i < NCH; i++) m_pos[i] = CENTER;
         end else begin
            if (m_busy && m_t == 0) m_led = !m_led;
            if (wr_en) begin
               for (int i = 0; i < NCH; i++)
                  if (wr_ch == 3'(i)) m_pos[i] = wr_pos;
            end
            if (!m_busy) begin
               if (en) begin
                  m_busy = 1'b1;
                  m_t    = 0;
               end
            end else if (m_t == FRAME_CYC - 1) begin
               if (en) m_t = 0;
               else    m_busy = 1'b0;
            end else begin
               m_t++;
            end
            if (m_busy && m_t == 0) begin
               for (int i = 0; i < NCH; i++) m_snap[i] = m_pos[i];
            end
         end
      end
   end

   initial begin
      logic [NCH-1:0] exp_s;
      bit             exp_fs;
      bit             exp_led;
      int             off;
      forever begin
         @(negedge clk);
         exp_s = '0;
         if (m_busy && m_t >= 1) begin
            off = m_t - 1;
            for (int k = 0; k < NCH; k++) begin
               if (off >= 0 && off < wid(m_snap[k])) exp_s = {{(NCH-1){1'b0}}, 1'b1} << k;
               off -= wid(m_snap[k]);
            end
         end
         exp_fs = m_busy && (m_t == 1);
`ifdef SERVO_SEQ_LED_EN
         exp_led = m_led;
`else
         exp_led = 1'b0;
`endif
         chk("cycle_outs", 32'({servo, busy, frame_start, led0}),
             32'({exp_s, m_busy, exp_fs, exp_led}));
      end
   end

   task automatic do_write(input logic [2:0] ch, input logic [POS_W-1:0] pos);
      wr_en  = 1'b1;
      wr_ch  = ch;
      wr_pos = pos;
      @(negedge clk);
      wr_en  = 1'b0;
   endtask

   task automatic measure_pulse(input logic [1:0] c, output int w);
      int n;
      n = 0;
      while (servo[c] && n < BUD) begin @(negedge clk); n++; end
      n = 0;
      while (!servo[c] && n < BUD) begin @(negedge clk); n++; end
      w = 0;
      while (servo[c] && w < BUD) begin @(negedge clk); w++; end
   endtask

   task automatic wait_high(input logic [1:0] c, input string tag);
      for (int i = 0; i < BUD && !servo[c]; i++) @(negedge clk);
      chk(tag, 32'(servo[c]), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < BUD && busy; i++) @(negedge clk);
      chk(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int  w;
      int  cnt;
      bit  prev;
      rst    = 1'b0;
      en     = 1'b0;
      wr_en  = 1'b0;
      wr_ch  = 3'd0;
      wr_pos = '0;
      #1 rst = 1'b1;
      #1;
      chk("reset_outs", 32'({servo, busy, frame_start, led0}), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Free run with centre positions; frame period and a centre pulse width.
      en = 1'b1;
      measure_pulse(2'd0, w);
      chk("w_ch0_center", w, wid(CENTER));
      prev = 1'b1;
      for (int i = 0; i < BUD && servo[0]; i++) @(negedge clk);
      for (int i = 0; i < BUD && !servo[0]; i++) @(negedge clk);
      cnt = 0;
      while (cnt < BUD) begin
         @(negedge clk);
         cnt++;
         if (servo[0] && !prev) break;
         prev = servo[0];
      end
      chk("frame_period", cnt, FRAME_CYC);
      measure_pulse(2'd3, w);
      chk("w_ch3_center", w, wid(CENTER));

      // Extreme positions written while stopped.
      en = 1'b0;
      wait_idle("idle_after_stop");
      do_write(3'd1, 8'd0);
      do_write(3'd2, 8'd255);
      en = 1'b1;
      measure_pulse(2'd1, w);
      chk("w_ch1_min", w, wid(8'd0));
      measure_pulse(2'd2, w);
      chk("w_ch2_max", w, wid(8'd255));

      // Write to ch0 during ch1 pulse only affects the next frame.
      wait_high(2'd1, "saw_ch1");
      do_write(3'd0, 8'd0);
      measure_pulse(2'd0, w);
      chk("w_ch0_next", w, wid(8'd0));

      // Out-of-range channel writes are dropped.
      do_write(3'd5, 8'd200);
      do_write(3'd7, 8'd50);
      measure_pulse(2'd1, w);
      chk("w_ch1_after_bad_wr", w, wid(8'd0));
      measure_pulse(2'd0, w);
      chk("w_ch0_after_bad_wr", w, wid(8'd0));

      // Stop mid-frame, stay quiet, restart.
      wait_high(2'd2, "saw_ch2");
      en = 1'b0;
      wait_idle("idle_after_midframe_stop");
      repeat (300) @(negedge clk);
      chk("quiet_after_stop", 32'({servo, busy}), 32'd0);
      en = 1'b1;
      @(negedge clk);
      chk("restart_load", 32'({busy, servo}), 32'({1'b1, 4'b0000}));
      @(negedge clk);
      chk("restart_pulse", 32'({servo[0], frame_start}), 32'b11);

      // Random writes and occasional enable toggles.
      for (int i = 0; i < 8 * FRAME_CYC; i++) begin
         wr_en = 1'b0;
         if ($urandom_range(39, 0) == 0) begin
            wr_en  = 1'b1;
            wr_ch  = 3'($urandom_range(7, 0));
            wr_pos = 8'($urandom_range(255, 0));
         end
         if ($urandom_range(1499, 0) == 0) en = !en;
         @(negedge clk);
      end
      wr_en = 1'b0;
      en    = 1'b1;

      // Asynchronous reset in the middle of a ch1 pulse.
      wait_high(2'd1, "saw_ch1_pre_rst");
      #2 rst = 1'b1;
      #1;
      chk("async_rst", 32'({servo, busy, frame_start}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      measure_pulse(2'd0, w);
      chk("w_ch0_post_rst", w, wid(CENTER));
      measure_pulse(2'd3, w);
      chk("w_ch3_post_rst", w, wid(CENTER));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
